// File: rtl/mic1_microsequencer_if.sv
// mic1_microsequencer_if
//   Bundles the microsequencer's MIR fields, ULA status, memory handshake and
//   sequencer status outputs.
//   master : control store / datapath side (drives MIR fields, ULA flags, MBR,
//            mem_ready; observes mpc/exec/flags/status)
//   slave  : the microsequencer itself
//   When MIC1_SEQ_STEP_EN is defined the bundle also carries step_mode/step.
interface mic1_microsequencer_if #(
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] next_addr;   // MIR NEXT_ADDRESS
    logic              jmpc;        // MIR JMPC
    logic              jamn;        // MIR JAMN
    logic              jamz;        // MIR JAMZ
    logic              mem_req;     // MIR read/fetch bit
    logic              alu_n;       // ULA N
    logic              alu_z;       // ULA Z
    logic [7:0]        mbr;         // opcode byte for JMPC
    logic              mem_ready;   // memory data valid
    logic [ADDR_W-1:0] mpc;         // current control-store address
    logic              exec;        // microinstruction commits this cycle
    logic              n_flag;      // latched N
    logic              z_flag;      // latched Z
    logic              halted;      // sequencer stopped
    logic              mem_fault;   // sticky memory timeout
`ifdef MIC1_SEQ_STEP_EN
    logic              step_mode;   // single-step mode enable
    logic              step;        // commit strobe while single-stepping
`endif

    modport master (
        output next_addr, jmpc, jamn, jamz, mem_req, alu_n, alu_z, mbr, mem_ready,
`ifdef MIC1_SEQ_STEP_EN
        output step_mode, step,
`endif
        input  mpc, exec, n_flag, z_flag, halted, mem_fault
    );

    modport slave (
        input  next_addr, jmpc, jamn, jamz, mem_req, alu_n, alu_z, mbr, mem_ready,
`ifdef MIC1_SEQ_STEP_EN
        input  step_mode, step,
`endif
        output mpc, exec, n_flag, z_flag, halted, mem_fault
    );
endinterface

// File: rtl/mic1_microsequencer.sv
// mic1_microsequencer
//   MIC-1 microprogram sequencer. Owns the MPC and forms the next
//   control-store address from NEXT_ADDRESS, the JAMN/JAMZ/JMPC bits, the ULA
//   N/Z outputs and MBR. Stalls while a memory read/fetch is outstanding and
//   stops for good at HALT_ADDR (or on a memory timeout).
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mic1_microsequencer_if.slave (MIR fields, ULA flags, MBR,
//            mem_ready in; mpc, exec, n_flag, z_flag, halted, mem_fault out)
// Optional feature
//   MIC1_SEQ_STEP_EN : adds step_mode/step; with step_mode=1 the RUN state
//   only commits on cycles where step=1.
module mic1_microsequencer #(
    parameter int              ADDR_W      = 9,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter logic [ADDR_W-1:0] HALT_ADDR  = {ADDR_W{1'b1}},
    parameter int              MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    mic1_microsequencer_if.slave bus
);
    // Counter only needs to reach MEM_TIMEOUT-1; with no timeout it simply wraps.
    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit HAS_TIMEOUT = (MEM_TIMEOUT != 0);

    typedef enum logic [1:0] {RUN, WAIT_MEM, HALT} state_t;

    state_t            stateReg, stateNext;
    logic [ADDR_W-1:0] mpcReg, mpcNext;
    logic              nReg, nNext;
    logic              zReg, zNext;
    logic              faultReg, faultNext;
    logic [CNT_W-1:0]  cntReg, cntNext;
    logic [ADDR_W-1:0] naWord;
    logic              stepOk;
    logic              timeoutHit;
    logic              execNow;

    // Next-address formation is pure OR: JAM bits can only set the top bit,
    // JMPC ORs the opcode into the low byte.
    always_comb begin
        naWord = bus.next_addr;
        naWord[ADDR_W-1] = bus.next_addr[ADDR_W-1]
                         | (bus.jamn & bus.alu_n)
                         | (bus.jamz & bus.alu_z);
        if (bus.jmpc) begin
            naWord[7:0] = bus.next_addr[7:0] | bus.mbr;
        end
    end

`ifdef MIC1_SEQ_STEP_EN
    assign stepOk = ~bus.step_mode | bus.step;
`else
    assign stepOk = 1'b1;
`endif

    assign timeoutHit = HAS_TIMEOUT && (cntReg == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        stateNext = stateReg;
        mpcNext   = mpcReg;
        nNext     = nReg;
        zNext     = zReg;
        faultNext = faultReg;
        cntNext   = cntReg;
        execNow   = 1'b0;
        case (stateReg)
            RUN: begin
                if (stepOk) begin
                    execNow = 1'b1;
                    mpcNext = naWord;
                    nNext   = bus.alu_n;
                    zNext   = bus.alu_z;
                    // Halt wins over a memory request in the same microinstruction.
                    if (naWord == HALT_ADDR) begin
                        stateNext = HALT;
                    end else if (bus.mem_req) begin
                        stateNext = WAIT_MEM;
                        cntNext   = '0;
                    end
                end
            end
            WAIT_MEM: begin
                cntNext = cntReg + 1'b1;
                // Data arriving on the last allowed cycle still counts as success.
                if (bus.mem_ready) begin
                    stateNext = RUN;
                end else if (timeoutHit) begin
                    stateNext = HALT;
                    faultNext = 1'b1;
                end
            end
            HALT: begin
            end
            default: begin
                stateNext = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= RUN;
            mpcReg   <= RESET_ADDR;
            nReg     <= 1'b0;
            zReg     <= 1'b0;
            faultReg <= 1'b0;
            cntReg   <= '0;
        end else begin
            stateReg <= stateNext;
            mpcReg   <= mpcNext;
            nReg     <= nNext;
            zReg     <= zNext;
            faultReg <= faultNext;
            cntReg   <= cntNext;
        end
    end

    assign bus.mpc       = mpcReg;
    assign bus.exec      = execNow;
    assign bus.n_flag    = nReg;
    assign bus.z_flag    = zReg;
    assign bus.halted    = (stateReg == HALT);
    assign bus.mem_fault = faultReg;
endmodule

// File: tb/tb_mic1_microsequencer.sv
module tb_mic1_microsequencer;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mic1_microsequencer_if #(.ADDR_W(9)) bus();

    mic1_microsequencer #(
        .ADDR_W(9), .RESET_ADDR(9'h000), .HALT_ADDR(9'h1FF), .MEM_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: a sequencer is either running, waiting (with a count of
    // stall cycles spent), or stopped.
    logic [8:0] mMpc;
    bit         mN, mZ, mStopped, mFault, mWaiting;
    int         mWaited;

    function automatic logic [8:0] nextAddrOf();
        logic [8:0] a;
        a = bus.next_addr;
        if ((bus.jamn && bus.alu_n) || (bus.jamz && bus.alu_z)) a = a | 9'h100;
        if (bus.jmpc) a = a | {1'b0, bus.mbr};
        return a;
    endfunction

    task automatic modelReset();
        mMpc = 9'h000; mN = 0; mZ = 0; mStopped = 0; mFault = 0; mWaiting = 0; mWaited = 0;
    endtask

    task automatic modelEdge();
        logic [8:0] a;
        if (mStopped) return;
        if (mWaiting) begin
            if (bus.mem_ready) mWaiting = 0;
            else if (mWaited + 1 >= TO) begin
                mWaiting = 0; mStopped = 1; mFault = 1;
            end else mWaited++;
        end else begin
            a = nextAddrOf();
            mN = bus.alu_n; mZ = bus.alu_z; mMpc = a;
            if (a == 9'h1FF) mStopped = 1;
            else if (bus.mem_req) begin mWaiting = 1; mWaited = 0; end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkModel(input string tag);
        chk({tag, ".mpc"},    16'(bus.mpc),       16'(mMpc));
        chk({tag, ".exec"},   16'(bus.exec),      16'(!mStopped && !mWaiting));
        chk({tag, ".n"},      16'(bus.n_flag),    16'(mN));
        chk({tag, ".z"},      16'(bus.z_flag),    16'(mZ));
        chk({tag, ".halted"}, 16'(bus.halted),    16'(mStopped));
        chk({tag, ".fault"},  16'(bus.mem_fault), 16'(mFault));
    endtask

    // One clock: compare against the model at the falling edge, then advance
    // both at the rising edge; returns 1ns after the edge.
    task automatic tick(input string tag);
        @(negedge clk);
        chkModel(tag);
        $display("cyc tag=%s mpc=%h exec=%b n=%b z=%b halted=%b fault=%b",
                 tag, bus.mpc, bus.exec, bus.n_flag, bus.z_flag, bus.halted, bus.mem_fault);
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic setIn(input logic [8:0] na, input bit jm, input bit jn, input bit jz,
                         input bit mr, input bit n, input bit z, input logic [7:0] b,
                         input bit rdy);
        bus.next_addr = na; bus.jmpc = jm; bus.jamn = jn; bus.jamz = jz;
        bus.mem_req = mr; bus.alu_n = n; bus.alu_z = z; bus.mbr = b; bus.mem_ready = rdy;
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #2;
        modelReset();
        chkModel(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
`ifdef MIC1_SEQ_STEP_EN
        bus.step_mode = 1'b0;
        bus.step = 1'b0;
`endif
        setIn(9'h005, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        doReset("reset");
        chk("first_exec", 16'(bus.exec), 16'd1);
        chk("first_mpc", 16'(bus.mpc), 16'h000);
        tick("boot");
        chk("mpc_5", 16'(bus.mpc), 16'h005);

        setIn(9'h010, 0, 0, 1, 0, 0, 1, 8'h00, 0);
        tick("jamz1");
        chk("jamz_mpc", 16'(bus.mpc), 16'h110);
        chk("jamz_zflag", 16'(bus.z_flag), 16'd1);
        setIn(9'h010, 0, 0, 1, 0, 0, 0, 8'h00, 0);
        tick("jamz0");
        chk("jamz0_mpc", 16'(bus.mpc), 16'h010);

        setIn(9'h000, 1, 0, 0, 0, 0, 0, 8'h60, 0);
        tick("jmpc");
        chk("jmpc_mpc", 16'(bus.mpc), 16'h060);
        setIn(9'h100, 1, 1, 0, 0, 1, 0, 8'h0A, 0);
        tick("jmpc_jamn");
        chk("jmpc_jamn_mpc", 16'(bus.mpc), 16'h10A);

        // Memory stall, ready after three wait cycles; ULA flags toggle meanwhile.
        setIn(9'h002, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        tick("to2");
        chk("mpc_2", 16'(bus.mpc), 16'h002);
        setIn(9'h003, 0, 0, 0, 1, 0, 0, 8'h00, 0);
        tick("memreq");
        chk("stall_mpc", 16'(bus.mpc), 16'h003);
        chk("stall_exec", 16'(bus.exec), 16'd0);
        setIn(9'h0AA, 0, 0, 0, 0, 1, 1, 8'h00, 0);
        tick("stall1");
        chk("stall1_n", 16'(bus.n_flag), 16'd0);
        tick("stall2");
        setIn(9'h0AA, 0, 0, 0, 0, 1, 1, 8'h00, 1);
        tick("ready");
        chk("resume_exec", 16'(bus.exec), 16'd1);
        chk("resume_mpc", 16'(bus.mpc), 16'h003);

        // Timeout: request with no ready ever.
        setIn(9'h007, 0, 0, 0, 1, 0, 0, 8'h00, 0);
        tick("to_req");
        setIn(9'h007, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < TO; i++) tick("to_wait");
        chk("to_halted", 16'(bus.halted), 16'd1);
        chk("to_fault", 16'(bus.mem_fault), 16'd1);
        chk("to_exec", 16'(bus.exec), 16'd0);
        doReset("to_reset");
        chk("rst_halted", 16'(bus.halted), 16'd0);
        chk("rst_fault", 16'(bus.mem_fault), 16'd0);

        // Halt address beats a memory request.
        setIn(9'h1FF, 0, 0, 0, 1, 0, 0, 8'h00, 0);
        tick("halt_req");
        chk("halt_halted", 16'(bus.halted), 16'd1);
        chk("halt_mpc", 16'(bus.mpc), 16'h1FF);
        for (int i = 0; i < 3; i++) begin
            setIn(9'(i), 1, 1, 1, 1, 1, 1, 8'hFF, 1);
            tick("halt_hold");
        end
        chk("halt_exec", 16'(bus.exec), 16'd0);
        chk("halt_mpc_held", 16'(bus.mpc), 16'h1FF);

        // Randomized segments, each started from reset.
        for (int s = 0; s < 25; s++) begin
            doReset("rnd_reset");
            for (int c = 0; c < 40; c++) begin
                setIn(($urandom_range(0, 99) == 0) ? 9'h1FF : 9'($urandom_range(0, 511)),
                      1'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                      8'($urandom), ($urandom_range(0, 2) == 0));
                tick("rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mic1_microsequencer.md
Name: mic1_microsequencer

Overview:
Microprogram sequencer for the MIC-1 datapath. It owns the MPC and computes the next control-store address from the MIR NEXT_ADDRESS/JAM fields, the ULA N/Z outputs and MBR. It latches the N/Z flags, stalls the microprogram while a memory read/fetch completes, and stops at a halt address. The control store is external: a combinational ROM addressed by mpc, driving the MIR fields back into this block and ctrlULA into the ULA.

Parameters:
ADDR_W, 9, control-store address width
RESET_ADDR, 9'h000, MPC value after reset
HALT_ADDR, 9'h1FF, entering this address halts the sequencer
MEM_TIMEOUT, 16, maximum WAIT_MEM cycles before fault; 0 = no timeout

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
next_addr  in  ADDR_W  MIR NEXT_ADDRESS field
jmpc  in  1  MIR JMPC bit
jamn  in  1  MIR JAMN bit
jamz  in  1  MIR JAMZ bit
mem_req  in  1  MIR read or fetch bit set in current microinstruction
alu_n  in  1  ULA N output (result negative)
alu_z  in  1  ULA Z output (result zero)
mbr  in  8  memory byte register, opcode for JMPC
mem_ready  in  1  memory read/fetch data valid
mpc  out  ADDR_W  current control-store address
exec  out  1  microinstruction at mpc commits this cycle; gates all datapath register writes
n_flag  out  1  latched N
z_flag  out  1  latched Z
halted  out  1  sequencer stopped
mem_fault  out  1  memory timeout occurred (sticky)

Behaviour:
- Reset (async, rst_n=0): mpc=RESET_ADDR, state=RUN, n_flag=0, z_flag=0, halted=0, mem_fault=0, wait counter=0. First cycle after release: exec=1.
- States: RUN, WAIT_MEM, HALT. exec=1 only in RUN (and, with step feature, only on step cycles).
- Next address, computed combinationally and applied at the rising edge when exec=1:
  - na = next_addr
  - na[8] |= (jamn & alu_n) | (jamz & alu_z)
  - if jmpc: na[7:0] = next_addr[7:0] | mbr
- At each exec edge: n_flag<=alu_n, z_flag<=alu_z, mpc<=na.
- RUN transitions:
  - na==HALT_ADDR -> HALT, mpc<=HALT_ADDR.
  - else mem_req=1 -> WAIT_MEM, counter cleared.
  - else stay in RUN.
  - HALT takes priority over mem_req.
- WAIT_MEM: mpc, flags held; exec=0; counter increments each cycle.
  - mem_ready=1 -> RUN next edge; the microinstruction at mpc executes in that following cycle.
  - MEM_TIMEOUT!=0 and counter==MEM_TIMEOUT-1 without mem_ready -> HALT, mem_fault<=1.
  - mem_ready and timeout in the same cycle: mem_ready wins.
- mem_ready while in RUN is ignored; no queuing.
- HALT: exec=0, halted=1, mpc held, all inputs ignored. Exit only via reset.
- Reset asserted mid-WAIT_MEM or in HALT: immediate return to the reset values.
- Address arithmetic is OR-only; no carries or wrap. JMPC with next_addr[7:0]=0 yields {next_addr[8], mbr}.
- Latency: one microinstruction per cycle in RUN. Each memory request costs 1 + (cycles until mem_ready) stall cycles.

Optional Feature:
MIC1_SEQ_STEP_EN
- Defined: adds inputs step_mode (1) and step (1).
  - When step_mode=1, RUN commits only on cycles with step=1. exec=step, and mpc/flags/state hold otherwise.
  - WAIT_MEM and HALT behaviour are unchanged.
  - step_mode=0 gives normal operation.
- Undefined: no extra ports; the sequencer free-runs.

Test Plan:
- Reset release, next_addr=9'h005, jam bits=0 -> mpc=0 with exec=1, then mpc=5 next cycle; n_flag=z_flag=0.
- next_addr=9'h010, jamz=1, alu_z=1 -> mpc=9'h110, z_flag=1. Same inputs with alu_z=0 -> mpc=9'h010.
- next_addr=9'h000, jmpc=1, mbr=8'h60 -> mpc=9'h060. Also next_addr=9'h100, jamn=1, alu_n=1, jmpc=1, mbr=8'h0A -> mpc=9'h10A.
- mem_req=1 at mpc=2 with next_addr=3, mem_ready asserted 3 cycles later -> mpc=3 and exec=0 for the stall cycles, then exec=1 one cycle after mem_ready; flags unchanged during the stall.
- MEM_TIMEOUT=4, mem_req=1, mem_ready never asserted -> after 4 WAIT_MEM cycles: halted=1, mem_fault=1, exec=0. rst_n pulse -> mpc=RESET_ADDR, halted=0, mem_fault=0.
- next_addr=9'h1FF with mem_req=1 -> HALT, not WAIT_MEM; mpc=9'h1FF held, exec=0 thereafter.
